traffic_light_monitor: RTL and testbench



---
 rtl/traffic_light_monitor.sv | 148 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for a red/green/yellow traffic light controller.
// Tracks phase and dwell, flags encoding, sequence and timing violations.
module traffic_light_monitor #(
  parameter int RED_MIN    = 3,
  parameter int RED_MAX    = 20,
  parameter int GREEN_MIN  = 3,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_MIN = 1,
  parameter int YELLOW_MAX = 5,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [15:0]      cycles_done,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_short,
  output logic             err_long,
  output logic             err_sticky,
  output logic [2:0]       err_code
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } phase_t;

  localparam logic [CNT_W-1:0] SAT = '1;

  phase_t           state, pat, succ, nxt_state;
  logic             valid, multi, first, nxt_first, inc_cyc;
  logic             e_onehot, e_seq, e_short, e_long, e_any;
  logic [CNT_W-1:0] cur_min, cur_max, dwell_inc, nxt_dwell;

  assign phase = state;
  assign valid = (red ^ yellow ^ green) & ~(red & yellow & green);
  assign multi = (red & yellow) | (red & green) | (yellow & green);
  assign dwell_inc = (dwell == SAT) ? dwell : dwell + 1'b1;
  assign e_any = e_onehot | e_seq | e_short | e_long;

  always_comb begin
    pat = red ? RED : (green ? GREEN : YELLOW);
    succ = SYNC;
    cur_min = '0;
    cur_max = '0;
    unique case (state)
      RED: begin
        succ = GREEN;
        cur_min = CNT_W'(RED_MIN);
        cur_max = CNT_W'(RED_MAX);
      end
      GREEN: begin
        succ = YELLOW;
        cur_min = CNT_W'(GREEN_MIN);
        cur_max = CNT_W'(GREEN_MAX);
      end
      YELLOW: begin
        succ = RED;
        cur_min = CNT_W'(YELLOW_MIN);
        cur_max = CNT_W'(YELLOW_MAX);
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_dwell = dwell;
    nxt_first = first;
    inc_cyc = 1'b0;
    e_onehot = 1'b0;
    e_seq = 1'b0;
    e_short = 1'b0;
    e_long = 1'b0;
    priority case (1'b1)
      state == SYNC: begin
        if (valid) begin
          nxt_state = pat;
          nxt_dwell = CNT_W'(1);
          nxt_first = 1'b1;
        end else if (multi) begin
          e_onehot = 1'b1;
        end
      end
      !valid: begin
        e_onehot = 1'b1;
        nxt_state = SYNC;
        nxt_dwell = '0;
      end
      pat == state: begin
        nxt_dwell = dwell_inc;
        e_long = (dwell_inc == cur_max + 1'b1);
      end
      pat == succ: begin
        // The first partial phase after sync or a jump has no MIN check.
        e_short = !first && (dwell < cur_min);
        inc_cyc = (pat == RED);
        nxt_state = pat;
        nxt_dwell = CNT_W'(1);
        nxt_first = 1'b0;
      end
      default: begin
        e_seq = 1'b1;
        nxt_state = pat;
        nxt_dwell = CNT_W'(1);
        nxt_first = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
      dwell <= '0;
      first <= 1'b1;
      cycles_done <= '0;
      err_onehot <= 1'b0;
      err_seq <= 1'b0;
      err_short <= 1'b0;
      err_long <= 1'b0;
      err_sticky <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state <= nxt_state;
      dwell <= nxt_dwell;
      first <= nxt_first;
      if (inc_cyc) cycles_done <= cycles_done + 16'd1;
      err_onehot <= e_onehot;
      err_seq <= e_seq;
      err_short <= e_short;
      err_long <= e_long;
      if (e_any) err_sticky <= 1'b1;
      if (e_any && err_code == 3'd0) begin
        err_code <= e_onehot ? 3'd1 :
                    e_seq    ? 3'd2 :
                    e_short  ? 3'd3 : 3'd4;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random lamp
// patterns checked against a rule-level reference model.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        red = 1'b0;
  logic        yellow = 1'b0;
  logic        green = 1'b0;
  logic [1:0]  phase;
  logic [7:0]  dwell;
  logic [15:0] cycles_done;
  logic        err_onehot, err_seq, err_short, err_long;
  logic        err_sticky;
  logic [2:0]  err_code;

  traffic_light_monitor dut (
    .clk(clk),
    .rst(rst),
    .red(red),
    .yellow(yellow),
    .green(green),
    .phase(phase),
    .dwell(dwell),
    .cycles_done(cycles_done),
    .err_onehot(err_onehot),
    .err_seq(err_seq),
    .err_short(err_short),
    .err_long(err_long),
    .err_sticky(err_sticky),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase numbers 0=sync 1=red 2=green 3=yellow, successor is p%3+1.
  int mins[4] = '{0, 3, 3, 1};
  int maxs[4] = '{0, 20, 20, 5};
  int m_phase, m_dwell, m_cyc, m_code;
  bit m_first, m_sticky;
  bit m_on, m_sq, m_sh, m_lg;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit y, input bit g, input bit rs);
    int n, p;
    m_on = 0; m_sq = 0; m_sh = 0; m_lg = 0;
    if (rs) begin
      m_phase = 0; m_dwell = 0; m_cyc = 0; m_code = 0;
      m_first = 1; m_sticky = 0;
      return;
    end
    n = int'(r) + int'(y) + int'(g);
    p = (n != 1) ? 0 : (r ? 1 : (g ? 2 : 3));
    if (m_phase == 0) begin
      if (n >= 2) m_on = 1;
      else if (n == 1) begin
        m_phase = p; m_dwell = 1; m_first = 1;
      end
    end else if (n != 1) begin
      m_on = 1; m_phase = 0; m_dwell = 0;
    end else if (p == m_phase) begin
      if (m_dwell < 255) m_dwell++;
      if (m_dwell == maxs[m_phase] + 1) m_lg = 1;
    end else if (p == m_phase % 3 + 1) begin
      if (!m_first && m_dwell < mins[m_phase]) m_sh = 1;
      if (p == 1) m_cyc = (m_cyc + 1) % 65536;
      m_phase = p; m_dwell = 1; m_first = 0;
    end else begin
      m_sq = 1; m_phase = p; m_dwell = 1; m_first = 1;
    end
    if (m_on || m_sq || m_sh || m_lg) begin
      m_sticky = 1;
      if (m_code == 0) m_code = m_on ? 1 : m_sq ? 2 : m_sh ? 3 : 4;
    end
  endtask

  task automatic step(input bit r, input bit y, input bit g,
                      input bit rs = 0);
    red = r; yellow = y; green = g; rst = rs;
    @(posedge clk);
    model(r, y, g, rs);
    #1;
    chk("phase", 32'(phase), 32'(m_phase));
    chk("dwell", 32'(dwell), 32'(m_dwell));
    chk("cycles_done", 32'(cycles_done), 32'(m_cyc));
    chk("err_onehot", 32'(err_onehot), 32'(m_on));
    chk("err_seq", 32'(err_seq), 32'(m_sq));
    chk("err_short", 32'(err_short), 32'(m_sh));
    chk("err_long", 32'(err_long), 32'(m_lg));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("err_code", 32'(err_code), 32'(m_code));
  endtask

  // p: 0 none, 1 red, 2 green, 3 yellow
  task automatic hold(input int p, input int n);
    for (int i = 0; i < n; i++) step(p == 1, p == 3, p == 2);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    bit [2:0] cur;
    do_reset();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_code", 32'(err_code), 0);
    hold(0, 3);

    // Legal cycle with minimum-ish dwells
    hold(1, 5); hold(2, 4); hold(3, 2); hold(1, 1);
    chk("a_cycles", 32'(cycles_done), 1);
    chk("a_dwell", 32'(dwell), 1);
    chk("a_sticky", 32'(err_sticky), 0);

    // Overlong green
    do_reset();
    hold(1, 5); hold(2, 20);
    chk("b_nolong20", 32'(err_long), 0);
    hold(2, 1);
    chk("b_long", 32'(err_long), 1);
    chk("b_code", 32'(err_code), 4);
    chk("b_sticky", 32'(err_sticky), 1);
    chk("b_dwell", 32'(dwell), 21);
    hold(2, 1);
    chk("b_long_once", 32'(err_long), 0);

    // Short green
    do_reset();
    hold(1, 5); hold(2, 2); hold(3, 1);
    chk("c_short", 32'(err_short), 1);
    chk("c_code", 32'(err_code), 3);
    chk("c_phase", 32'(phase), 3);

    // Illegal jump red->yellow, then partial yellow exempt from MIN
    do_reset();
    hold(1, 5); hold(3, 1);
    chk("d_seq", 32'(err_seq), 1);
    chk("d_phase", 32'(phase), 3);
    chk("d_dwell", 32'(dwell), 1);
    hold(3, 1); hold(1, 1);
    chk("d_noshort", 32'(err_short), 0);
    chk("d_cycles", 32'(cycles_done), 1);

    // Two lamps at once
    do_reset();
    hold(1, 3);
    step(1, 0, 1);
    chk("e_onehot", 32'(err_onehot), 1);
    chk("e_phase", 32'(phase), 0);
    chk("e_dwell", 32'(dwell), 0);
    chk("e_code", 32'(err_code), 1);

    // Reset during green with sticky error
    hold(1, 3); hold(2, 3);
    chk("f_pre_sticky", 32'(err_sticky), 1);
    step(0, 0, 1, 1);
    chk("f_phase", 32'(phase), 0);
    chk("f_dwell", 32'(dwell), 0);
    chk("f_sticky", 32'(err_sticky), 0);
    chk("f_code", 32'(err_code), 0);

    // Legal controller-like run with random in-range dwells
    do_reset();
    for (int c = 0; c < 40; c++) begin
      hold(1, int'($urandom_range(20, 3)));
      hold(2, int'($urandom_range(20, 3)));
      hold(3, int'($urandom_range(5, 1)));
    end
    hold(1, 1);
    chk("g_cycles", 32'(cycles_done), 40);
    chk("g_sticky", 32'(err_sticky), 0);
    chk("g_code", 32'(err_code), 0);

    // Random lamp patterns, long holds and sporadic resets
    cur = 3'b100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 30) cur = 3'($urandom_range(7));
      if ($urandom_range(299) == 0) begin
        for (int k = 0; k < 260; k++) step(cur[2], cur[1], cur[0]);
      end
      step(cur[2], cur[1], cur[0], $urandom_range(199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
